// File: rtl/filter_scan_ctrl.sv
// Multi-channel debounce scheduler: one shared 3-sample agreement filter
// time-multiplexed over NCH inputs, with level changes reported as valid/ready events.
module filter_scan_ctrl #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned CW    = 3,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic [NCH-1:0]   sig_in,
  output logic [NCH-1:0]   sig_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CW-1:0]    evt_chan,
  output logic             evt_level,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {StIdle, StScan, StWait} state_e;

  state_e           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [CW-1:0]    r_ch;
  logic [2:0]       r_hist [NCH];
  logic [NCH-1:0]   r_sig_out;
  logic             r_evt_valid;
  logic [CW-1:0]    r_evt_chan;
  logic             r_evt_level;
  logic             r_overrun;

  logic             w_tick;
  logic             w_last;
  logic             w_cur;
  logic [2:0]       w_h;
  logic             w_change;

  assign w_tick   = enable && (r_cnt == div);
  assign w_last   = (r_ch == CW'(NCH - 1));
  assign w_cur    = r_sig_out[r_ch];
  assign w_h      = {r_hist[r_ch][1:0], sig_in[r_ch]};
  assign w_change = ((w_h == 3'b111) && !w_cur) || ((w_h == 3'b000) && w_cur);

  // Counting up past a lowered div wraps naturally at 2^DIV_W.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_ch        <= '0;
      r_sig_out   <= '0;
      r_evt_valid <= 1'b0;
      r_evt_chan  <= '0;
      r_evt_level <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        r_hist[i] <= 3'b000;
      end
    end else begin
      if (w_tick && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (w_tick) begin
            r_state <= StScan;
            r_ch    <= '0;
          end
        end
        StScan: begin
          r_hist[r_ch] <= w_h;
          if (w_change) begin
            r_sig_out[r_ch] <= ~w_cur;
            r_evt_chan      <= r_ch;
            r_evt_level     <= ~w_cur;
            r_evt_valid     <= 1'b1;
            r_state         <= StWait;
          end else if (w_last) begin
            r_state <= StIdle;
          end else begin
            r_ch <= r_ch + CW'(1);
          end
        end
        StWait: begin
          // Scan is frozen on r_ch until the consumer takes the event.
          if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
            if (w_last) begin
              r_state <= StIdle;
            end else begin
              r_state <= StScan;
              r_ch    <= r_ch + CW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sig_out   = r_sig_out;
  assign evt_valid = r_evt_valid;
  assign evt_chan  = r_evt_chan;
  assign evt_level = r_evt_level;
  assign overrun   = r_overrun;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Directed bench for filter_scan_ctrl: reset, debounce, glitch rejection, burst order,
// backpressure, overrun and reset during a pending event.
module tb_filter_scan_ctrl;
  localparam int NCH   = 8;
  localparam int CW    = 3;
  localparam int DIV_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [NCH-1:0]   sig_in = '0;
  logic             evt_ready = 1'b1;
  logic [NCH-1:0]   sig_out;
  logic             evt_valid;
  logic [CW-1:0]    evt_chan;
  logic             evt_level;
  logic             busy;
  logic             overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int ev_chan[$];
  int ev_level[$];
  logic [NCH-1:0] ev_sig[$];

  filter_scan_ctrl #(.NCH(NCH), .CW(CW), .DIV_W(DIV_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .div      (div),
    .sig_in   (sig_in),
    .sig_out  (sig_out),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_chan (evt_chan),
    .evt_level(evt_level),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b0;
    sig_in    = '0;
    evt_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic wait_busy(input int limit);
    int t;
    t = 0;
    while (!busy && t < limit) begin
      step();
      t++;
    end
    if (!busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL scan_start: busy=0 after %0d cycles, expected 1", limit);
    end
  endtask

  // Runs one full scan, logging every handshake; len = cycles with busy high.
  task automatic run_scan(output int len);
    ev_chan.delete();
    ev_level.delete();
    ev_sig.delete();
    len = 0;
    wait_busy(200);
    while (busy && len < 400) begin
      len++;
      if (evt_valid && evt_ready) begin
        ev_chan.push_back(int'(evt_chan));
        ev_level.push_back(int'(evt_level));
        ev_sig.push_back(sig_out);
      end
      step();
    end
  endtask

  task automatic test_reset();
    int t;
    reset     = 1'b0;
    enable    = 1'b1;
    div       = 16'd4;
    sig_in    = 8'hFF;
    evt_ready = 1'b1;
    step();
    step();
    n_tests++;
    if (sig_out !== 8'h00 || evt_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
        evt_chan !== 3'd0 || evt_level !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: sig_out=%h valid=%b busy=%b ovr=%b chan=%0d lvl=%b, expected all 0",
               sig_out, evt_valid, busy, overrun, evt_chan, evt_level);
    end
    reset = 1'b1;
    t = 0;
    while (!busy && t < 50) begin
      step();
      t++;
    end
    n_tests++;
    if (t != 5) begin
      n_fail++;
      $display("FAIL first_tick: busy after %0d cycles, expected 5", t);
    end
    do_reset();
  endtask

  task automatic test_rise();
    int len;
    do_reset();
    div    = 16'd15;
    sig_in = 8'h04;
    enable = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      run_scan(len);
      n_tests++;
      if (ev_chan.size() != 0 || sig_out !== 8'h00) begin
        n_fail++;
        $display("FAIL rise_early: scan %0d events=%0d sig_out=%h, expected 0 and 00",
                 s, ev_chan.size(), sig_out);
      end
    end
    run_scan(len);
    n_tests++;
    if (ev_chan.size() != 1) begin
      n_fail++;
      $display("FAIL rise_count: events=%0d, expected 1", ev_chan.size());
    end else if (ev_chan[0] != 2 || ev_level[0] != 1 || ev_sig[0] !== 8'h04) begin
      n_fail++;
      $display("FAIL rise_event: chan=%0d lvl=%0d sig_out=%h, expected 2 1 04",
               ev_chan[0], ev_level[0], ev_sig[0]);
    end
    n_tests++;
    if (len != 9) begin
      n_fail++;
      $display("FAIL rise_len: scan length %0d, expected 9", len);
    end
    sig_in = 8'h00;
    for (int s = 1; s <= 2; s++) begin
      run_scan(len);
      n_tests++;
      if (ev_chan.size() != 0 || sig_out !== 8'h04) begin
        n_fail++;
        $display("FAIL fall_early: scan %0d events=%0d sig_out=%h, expected 0 and 04",
                 s, ev_chan.size(), sig_out);
      end
    end
    run_scan(len);
    n_tests++;
    if (ev_chan.size() != 1) begin
      n_fail++;
      $display("FAIL fall_count: events=%0d, expected 1", ev_chan.size());
    end else if (ev_chan[0] != 2 || ev_level[0] != 0 || sig_out !== 8'h00) begin
      n_fail++;
      $display("FAIL fall_event: chan=%0d lvl=%0d sig_out=%h, expected 2 0 00",
               ev_chan[0], ev_level[0], sig_out);
    end
  endtask

  task automatic test_glitch();
    int len;
    logic [12:0] pat;
    pat = 13'b0101010101011;  // bit i drives scan i: 1,1,0 then alternating 1,0,...
    do_reset();
    div    = 16'd15;
    enable = 1'b1;
    for (int i = 0; i < 13; i++) begin
      sig_in = pat[i] ? 8'h20 : 8'h00;
      run_scan(len);
      n_tests++;
      if (ev_chan.size() != 0 || sig_out[5] !== 1'b0 || len != 8) begin
        n_fail++;
        $display("FAIL glitch: scan %0d events=%0d sig_out=%h len=%0d, expected 0 00 8",
                 i, ev_chan.size(), sig_out, len);
      end
    end
  endtask

  task automatic test_burst();
    int len;
    do_reset();
    div    = 16'd63;
    sig_in = 8'hFF;
    enable = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      run_scan(len);
      n_tests++;
      if (ev_chan.size() != 0 || len != 8) begin
        n_fail++;
        $display("FAIL burst_early: scan %0d events=%0d len=%0d, expected 0 8",
                 s, ev_chan.size(), len);
      end
    end
    run_scan(len);
    n_tests++;
    if (ev_chan.size() != 8 || len != 16 || sig_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL burst_scan: events=%0d len=%0d sig_out=%h, expected 8 16 ff",
               ev_chan.size(), len, sig_out);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_tests++;
        if (ev_chan[k] != k || ev_level[k] != 1) begin
          n_fail++;
          $display("FAIL burst_order: event %0d chan=%0d lvl=%0d, expected %0d 1",
                   k, ev_chan[k], ev_level[k], k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int len;
    bit stalled;
    do_reset();
    div    = 16'd63;
    sig_in = 8'hFF;
    enable = 1'b1;
    run_scan(len);
    run_scan(len);
    ev_chan.delete();
    stalled = 1'b0;
    len = 0;
    wait_busy(200);
    while (busy && len < 400) begin
      len++;
      if (evt_valid) begin
        if (evt_chan == 3'd3 && !stalled) begin
          evt_ready = 1'b0;
          stalled   = 1'b1;
          repeat (10) begin
            step();
            len++;
            n_tests++;
            if (evt_valid !== 1'b1 || evt_chan !== 3'd3 || evt_level !== 1'b1 ||
                sig_out !== 8'h0F) begin
              n_fail++;
              $display("FAIL bp_hold: valid=%b chan=%0d lvl=%b sig_out=%h, expected 1 3 1 0f",
                       evt_valid, evt_chan, evt_level, sig_out);
            end
          end
          evt_ready = 1'b1;
        end
        ev_chan.push_back(int'(evt_chan));
      end
      step();
    end
    n_tests++;
    if (!stalled || ev_chan.size() != 8 || len != 26 || sig_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL bp_scan: stalled=%0d events=%0d len=%0d sig_out=%h, expected 1 8 26 ff",
               stalled, ev_chan.size(), len, sig_out);
    end else begin
      for (int k = 3; k < 8; k++) begin
        n_tests++;
        if (ev_chan[k] != k) begin
          n_fail++;
          $display("FAIL bp_order: event %0d chan=%0d, expected %0d", k, ev_chan[k], k);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int len;
    int idle_busy;
    do_reset();
    div    = 16'd2;
    sig_in = 8'h00;
    enable = 1'b1;
    wait_busy(20);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_initial: overrun=%b, expected 0", overrun);
    end
    len = 0;
    while (busy && len < 100) begin
      len++;
      step();
    end
    n_tests++;
    if (len != 8 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: len=%0d overrun=%b, expected 8 1", len, overrun);
    end
    wait_busy(20);
    enable = 1'b0;
    len = 0;
    while (busy && len < 100) begin
      len++;
      step();
    end
    idle_busy = 0;
    repeat (40) begin
      if (busy) idle_busy++;
      step();
    end
    n_tests++;
    if (len != 8 || idle_busy != 0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_disable: len=%0d busy_cycles=%0d overrun=%b, expected 8 0 1",
               len, idle_busy, overrun);
    end
  endtask

  task automatic test_reset_wait();
    int t;
    do_reset();
    div       = 16'd15;
    sig_in    = 8'hFF;
    evt_ready = 1'b0;
    enable    = 1'b1;
    t = 0;
    while (!evt_valid && t < 200) begin
      step();
      t++;
    end
    repeat (40) step();
    n_tests++;
    if (evt_valid !== 1'b1 || busy !== 1'b1 || overrun !== 1'b1 || sig_out !== 8'h01 ||
        evt_chan !== 3'd0) begin
      n_fail++;
      $display("FAIL wait_state: valid=%b busy=%b ovr=%b sig_out=%h chan=%0d, expected 1 1 1 01 0",
               evt_valid, busy, overrun, sig_out, evt_chan);
    end
    reset = 1'b0;
    step();
    n_tests++;
    if (evt_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || sig_out !== 8'h00) begin
      n_fail++;
      $display("FAIL wait_reset: valid=%b busy=%b ovr=%b sig_out=%h, expected 0 0 0 00",
               evt_valid, busy, overrun, sig_out);
    end
    reset     = 1'b1;
    evt_ready = 1'b1;
    enable    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_burst();
    test_backpressure();
    test_overrun();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
